// File: rtl/rca_arbiter_seq.sv
// -----------------------------------------------------------------------------
// rca_arbiter_seq
//
// Shares one external 4-bit ripple-carry adder between two requesters. Each
// request is an add of two W-bit operands (W = 4*NIBBLES). The block runs the
// add nibble-serially over the external adder, LSB nibble first, and keeps the
// carry in a register between cycles. The winner is chosen round-robin. This
// block only sequences the adder; it does no arithmetic of its own.
//
// Optional build macro: RCA_ARB_OVF_FLAG_EN adds a two's-complement overflow
// flag output (ovf) that is updated and held together with result.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   req0/a0/b0/cin0       requester 0 request, operands, carry-in
//   req1/a1/b1/cin1       requester 1 request, operands, carry-in
//   gnt0/gnt1             one-cycle pulse: operands captured
//   done0/done1           one-cycle pulse: result valid
//   busy                  high whenever the FSM is not IDLE
//   result/cout           sum and carry-out of the last completed operation
//   ovf                   signed overflow of last operation (macro only)
//   add_a/add_b/add_cin   nibble operands driven to the external adder
//   add_sum/add_cout      external adder outputs
// -----------------------------------------------------------------------------
module rca_arbiter_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0,
  input  logic [4*NIBBLES-1:0] a0,
  input  logic [4*NIBBLES-1:0] b0,
  input  logic                 cin0,
  input  logic                 req1,
  input  logic [4*NIBBLES-1:0] a1,
  input  logic [4*NIBBLES-1:0] b1,
  input  logic                 cin1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 done0,
  output logic                 done1,
  output logic                 busy,
  output logic [4*NIBBLES-1:0] result,
  output logic                 cout,
`ifdef RCA_ARB_OVF_FLAG_EN
  output logic                 ovf,
`endif
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  output logic                 add_cin,
  input  logic [3:0]           add_sum,
  input  logic                 add_cout
);

  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_next;

  // Operands and partial sum kept as nibble arrays so the serial index
  // selects a slice directly.
  logic [NIBBLES-1:0][3:0] a_reg, b_reg, shadow;
  logic                    carry;
  logic [IDX_W-1:0]        idx;
  logic                    ptr;    // 0: requester 0 favoured, 1: requester 1
  logic                    owner;  // requester currently being served

  logic grant;
  logic win1;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    win1       = 1'b0;
    add_a      = 4'h0;
    add_b      = 4'h0;
    add_cin    = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          grant      = 1'b1;
          // Requester 1 wins when it is alone, or when both request and
          // the pointer favours it.
          win1       = req1 && (!req0 || ptr);
          state_next = RUN;
        end
      end
      RUN: begin
        add_a   = a_reg[idx];
        add_b   = b_reg[idx];
        add_cin = carry;
        if (idx == LAST_IDX) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      shadow <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      ptr    <= 1'b0;
      owner  <= 1'b0;
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      done0  <= 1'b0;
      done1  <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
`ifdef RCA_ARB_OVF_FLAG_EN
      ovf    <= 1'b0;
`endif
    end else begin
      state <= state_next;
      // Grant and done are single-cycle pulses.
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            owner <= win1;
            a_reg <= win1 ? a1 : a0;
            b_reg <= win1 ? b1 : b0;
            carry <= win1 ? cin1 : cin0;
            idx   <= '0;
            gnt0  <= !win1;
            gnt1  <= win1;
          end
        end
        RUN: begin
          shadow[idx] <= add_sum;
          carry       <= add_cout;
          idx         <= idx + IDX_W'(1);
        end
        DONE: begin
          result <= shadow;
          cout   <= carry;
          done0  <= !owner;
          done1  <= owner;
          ptr    <= !owner;
`ifdef RCA_ARB_OVF_FLAG_EN
          ovf    <= (a_reg[NIBBLES-1][3] == b_reg[NIBBLES-1][3]) &&
                    (shadow[NIBBLES-1][3] != a_reg[NIBBLES-1][3]);
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rca_arbiter_seq.sv
// -----------------------------------------------------------------------------
// tb_rca_arbiter_seq
//
// Directed bench for rca_arbiter_seq with NIBBLES=4. The external 4-bit
// ripple-carry adder is modelled here as plain combinational addition.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_rca_arbiter_seq;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk, rst_n;
  logic         req0, cin0, req1, cin1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         gnt0, gnt1, done0, done1, busy, cout;
  logic [W-1:0] result;
  logic [3:0]   add_a, add_b, add_sum;
  logic         add_cin, add_cout;
`ifdef RCA_ARB_OVF_FLAG_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  rca_arbiter_seq #(.NIBBLES(NIB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .a0(a0), .b0(b0), .cin0(cin0),
    .req1(req1), .a1(a1), .b1(b1), .cin1(cin1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .busy(busy), .result(result), .cout(cout),
`ifdef RCA_ARB_OVF_FLAG_EN
    .ovf(ovf),
`endif
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  // External adder.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0 = 0; req1 = 0; cin0 = 0; cin1 = 0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({gnt0, gnt1, done0, done1, busy, cout} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 000000", {gnt0, gnt1, done0, done1, busy, cout});
    end
    checks++;
    if (result !== 16'h0) begin
      errors++;
      $display("FAIL reset_result got %h want 0000", result);
    end
    checks++;
    if ({add_a, add_b, add_cin} !== 9'b0) begin
      errors++;
      $display("FAIL reset_adder got %h want 000", {add_a, add_b, add_cin});
    end
`ifdef RCA_ARB_OVF_FLAG_EN
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf got %b want 0", ovf);
    end
`endif
    rst_n = 1'b1;
  endtask

  // One operation from a single requester: grant, adder nibbles, latency and
  // the final sum/carry.
  task automatic test_single_op(input logic who, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic cin,
                                input logic [W-1:0] exp_res, input logic exp_cout,
                                input logic exp_ovf);
    if (!who) begin req0 = 1; a0 = a; b0 = b; cin0 = cin; end
    else      begin req1 = 1; a1 = a; b1 = b; cin1 = cin; end
    tick();
    // Operands only need to be valid in the grant cycle.
    req0 = 0; req1 = 0;
    a0 = 16'hDEAD; b0 = 16'hBEEF; a1 = 16'hDEAD; b1 = 16'hBEEF;
    cin0 = 1; cin1 = 1;
    checks++;
    if ({gnt0, gnt1, busy} !== {!who, who, 1'b1}) begin
      errors++;
      $display("FAIL grant_%0d gnt0/gnt1/busy got %b want %b", who,
               {gnt0, gnt1, busy}, {!who, who, 1'b1});
    end
    for (int i = 0; i < NIB; i++) begin
      checks++;
      if ({add_a, add_b} !== {a[4*i +: 4], b[4*i +: 4]}) begin
        errors++;
        $display("FAIL adder_nibble_%0d got a=%h b=%h want a=%h b=%h", i,
                 add_a, add_b, a[4*i +: 4], b[4*i +: 4]);
      end
      if (i == 0) begin
        checks++;
        if (add_cin !== cin) begin
          errors++;
          $display("FAIL adder_cin0 got %b want %b", add_cin, cin);
        end
      end
      checks++;
      if ({done0, done1} !== 2'b00) begin
        errors++;
        $display("FAIL early_done cycle %0d got %b want 00", i, {done0, done1});
      end
      tick();
    end
    // DONE state: adder idle, still busy, no done yet.
    checks++;
    if ({busy, done0, done1, add_a, add_b, add_cin} !== {1'b1, 11'b0}) begin
      errors++;
      $display("FAIL done_state got %b want 100000000000",
               {busy, done0, done1, add_a, add_b, add_cin});
    end
    tick();
    checks++;
    if ({done0, done1, busy} !== {!who, who, 1'b0}) begin
      errors++;
      $display("FAIL done_pulse got %b want %b", {done0, done1, busy}, {!who, who, 1'b0});
    end
    checks++;
    if ({cout, result} !== {exp_cout, exp_res}) begin
      errors++;
      $display("FAIL sum got cout=%b result=%h want cout=%b result=%h",
               cout, result, exp_cout, exp_res);
    end
`ifdef RCA_ARB_OVF_FLAG_EN
    checks++;
    if (ovf !== exp_ovf) begin
      errors++;
      $display("FAIL ovf got %b want %b", ovf, exp_ovf);
    end
`else
    if (exp_ovf === 1'bx) $display("unexpected X expectation");
`endif
    tick();
    checks++;
    if ({done0, done1, result} !== {2'b00, exp_res}) begin
      errors++;
      $display("FAIL hold got done=%b result=%h want done=00 result=%h",
               {done0, done1}, result, exp_res);
    end
  endtask

  // Both requesters held from reset: alternating grants, one idle cycle.
  task automatic test_round_robin();
    logic [3:0] order;
    int ngnt, ndone, low_run;
    logic seen_gnt;
    rst_n = 0;
    a0 = 16'h1111; b0 = 16'h2222; cin0 = 0;
    a1 = 16'h0F0F; b1 = 16'h0101; cin1 = 0;
    req0 = 1; req1 = 1;
    #3;
    rst_n = 1;
    ngnt = 0; ndone = 0; low_run = 0; seen_gnt = 0; order = '0;
    for (int cyc = 0; cyc < 40 && ndone < 4; cyc++) begin
      tick();
      checks++;
      if ((gnt0 && gnt1) || (done0 && done1)) begin
        errors++;
        $display("FAIL rr_overlap got gnt=%b done=%b", {gnt0, gnt1}, {done0, done1});
      end
      if (gnt0 || gnt1) begin
        if (ngnt < 4) order[ngnt] = gnt1;
        ngnt++;
        if (seen_gnt) begin
          checks++;
          if (low_run != 1) begin
            errors++;
            $display("FAIL rr_idle_gap got %0d want 1", low_run);
          end
        end
        seen_gnt = 1;
        if (ngnt == 4) begin req0 = 0; req1 = 0; end
      end
      if (!busy) low_run++;
      else low_run = 0;
      if (done0 || done1) begin
        ndone++;
        checks++;
        if (result !== (done0 ? 16'h3333 : 16'h1010)) begin
          errors++;
          $display("FAIL rr_result got %h want %h", result, done0 ? 16'h3333 : 16'h1010);
        end
      end
    end
    checks++;
    if (ngnt != 4 || ndone != 4 || order !== 4'b1010) begin
      errors++;
      $display("FAIL rr_order got grants=%0d dones=%0d order=%b want 4 4 1010",
               ngnt, ndone, order);
    end
  endtask

  // Reset pulse inside a requester 1 operation.
  task automatic test_reset_mid_run();
    logic saw_done;
    req1 = 1; a1 = 16'h1234; b1 = 16'h1111; cin1 = 0;
    tick();
    req1 = 0;
    checks++;
    if (gnt1 !== 1'b1) begin
      errors++;
      $display("FAIL mid_gnt1 got %b want 1", gnt1);
    end
    tick();
    #1 rst_n = 0;
    #1;
    checks++;
    if ({gnt0, gnt1, done0, done1, busy, cout, result, add_a, add_b, add_cin} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs busy=%b result=%h add_a=%h", busy, result, add_a);
    end
    #1 rst_n = 1;
    saw_done = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done1 || busy) saw_done = 1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_no_done got activity=1 want 0");
    end
    req0 = 1; req1 = 1;
    tick();
    req0 = 0; req1 = 0;
    checks++;
    if ({gnt0, gnt1} !== 2'b10) begin
      errors++;
      $display("FAIL mid_ptr got %b want 10", {gnt0, gnt1});
    end
    repeat (6) tick();
  endtask

  // req1 raised and dropped while busy with requester 0: ignored.
  task automatic test_busy_ignore();
    logic saw1;
    req0 = 1; a0 = 16'h0001; b0 = 16'h0002; cin0 = 0;
    tick();
    req0 = 0;
    saw1 = 0;
    for (int i = 0; i < 10; i++) begin
      req1 = (i == 1 || i == 2);
      a1 = 16'hFFFF; b1 = 16'hFFFF;
      tick();
      if (gnt1 || done1) saw1 = 1;
    end
    req1 = 0;
    checks++;
    if (saw1 !== 1'b0) begin
      errors++;
      $display("FAIL busy_ignore got req1 activity=1 want 0");
    end
    checks++;
    if (result !== 16'h0003) begin
      errors++;
      $display("FAIL busy_result got %h want 0003", result);
    end
  endtask

  initial begin
    test_reset();
    test_single_op(1'b0, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
    test_single_op(1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    test_single_op(1'b0, 16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0);
    test_single_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    test_round_robin();
    test_reset_mid_run();
    test_busy_ignore();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
